pid_cordic_sched: RTL and testbench
===================================

Name: pid_cordic_sched

Overview:
- Periodic sample-and-compute sequencer for the PID/CORDIC datapath.
- Generates the sample tick, latches the ADC sample as PID feedback, and waits a fixed PID latency.
- Saturates the PID result and loads it into the CORDIC with a write pulse, then waits the CORDIC latency and presents the magnitude with a valid strobe.
- Also owns the host configuration registers (target, gains), which it applies only at sample boundaries.

Parameters:
- SAMPLE_DIV, 1000: clock cycles per sample period (>=PID_LAT+CORDIC_LAT+3).
- PID_LAT, 4: cycles from y/target change to pid_result valid (>=1).
- CORDIC_LAT, 16: cycles from cordic_we to cordic_result valid (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  enables the sample divider.
- adc_data  in  12  raw ADC sample.
- cfg_wr  in  1  host write strobe.
- cfg_addr  in  2  0=target, 1=para, 2=control, 3=reserved.
- cfg_wdata  in  12  host write data.
- cfg_ack  out  1  one-cycle ack, the cycle after cfg_wr.
- target  out  12  active setpoint to PID.
- para  out  12  active gains {kd,ki,kp} to PID.
- y  out  12  latched feedback sample to PID.
- pid_we  out  1  pulse marking a new PID input.
- pid_data  out  12  equals y, qualified by pid_we.
- pid_result  in  17  PID output, two's complement.
- cordic_we  out  1  load pulse to CORDIC input register.
- cordic_data  out  12  saturated PID result.
- cordic_result  in  12  CORDIC magnitude.
- mag_out  out  12  captured magnitude.
- mag_valid  out  1  one-cycle strobe for mag_out.
- busy  out  1  high whenever state != IDLE.
- overrun_cnt  out  8  saturating count of ticks missed while busy.

Behaviour:
- Reset: every output and register is 0, state is IDLE, divider is 0. Reset may assert at any time; it aborts any operation and no mag_valid is produced.
- Divider:
  - Counts 0..SAMPLE_DIV-1 while en=1, then wraps.
  - tick asserts for one cycle when the count is SAMPLE_DIV-1.
  - While en=0 the divider is held at 0 and an in-flight operation completes normally.
- Shadow registers: cfg_wr at addr 0/1 writes shadow_target/shadow_para. cfg_ack pulses the next cycle for every address.
- Control register (addr 2): bit0=1 clears overrun_cnt. A tick overrun in the same cycle loses to the clear. Addr 3 is acked and ignored.
- FSM states: IDLE, PID_WAIT, CORDIC_LOAD, CORDIC_WAIT, DONE.
- IDLE, on tick (cycle T):
  - y<=adc_data; target<=shadow_target; para<=shadow_para.
  - pid_we pulses at T+1.
  - cnt<=PID_LAT; go to PID_WAIT.
  - A cfg_wr in the same cycle updates the shadow only; it is not seen until the next tick.
- PID_WAIT:
  - cnt decrements each cycle.
  - When cnt==1: cordic_data<=sat12(pid_result); go to CORDIC_LOAD.
- sat12 rule:
  - Signed clamp to [-2048, 2047].
  - pid_result > 2047 gives 12'h7FF; pid_result < -2048 gives 12'h800; otherwise pid_result[11:0].
- CORDIC_LOAD: one cycle at T+PID_LAT+1; cordic_we=1; cnt<=CORDIC_LAT; go to CORDIC_WAIT.
- CORDIC_WAIT: cnt decrements. When cnt==1: mag_out<=cordic_result; go to DONE.
- DONE: mag_valid=1 for one cycle at T+PID_LAT+CORDIC_LAT+2, then IDLE.
- Overrun: a tick outside IDLE is dropped and overrun_cnt increments, saturating at 255.
- target, para and y are stable from T+1 until the next accepted tick.

Decomposition:
- Shared package: FSM state enum, cfg address constants (ADDR_TARGET, ADDR_PARA, ADDR_CTRL), and the 12-bit saturation limits.
- One natural sub-module: pid_cordic_tick_div (parameterised divider with enable, emits tick).
- The FSM, shadow registers and saturation remain in the top.

Test Plan:
- SAMPLE_DIV=40, PID_LAT=4, CORDIC_LAT=16, en=1, adc_data=12'h123 -> tick at cycle 39, y=12'h123 and pid_we at cycle 40, cordic_we at cycle 44, mag_valid at cycle 61.
- pid_result=17'h00800 (2048) -> cordic_data=12'h7FF; pid_result=17'h1F000 (-4096) -> 12'h800; pid_result=17'h1FFFF (-1) -> 12'hFFF.
- cfg_wr addr0 = 12'h0AA mid-operation -> cfg_ack next cycle; target unchanged until the next tick, then 12'h0AA.
- SAMPLE_DIV=10 with total latency 22 -> ticks while busy are dropped, overrun_cnt increments per dropped tick; a ctrl write of 1 clears it to 0.
- Assert rst during CORDIC_WAIT -> all outputs 0 immediately, no mag_valid; after release, the next tick occurs SAMPLE_DIV cycles after en.
- en deasserted during PID_WAIT -> the operation completes with mag_valid; no further ticks, divider held at 0.

Source files
------------

// File: rtl/pid_cordic_sched_pkg.sv
// Shared types and constants for the PID/CORDIC sample sequencer.
// Holds the FSM encoding, host register map and 12-bit saturation helper.
package pid_cordic_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PID_WAIT,
    CORDIC_LOAD,
    CORDIC_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_PARA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam logic [11:0] SAT_MAX = 12'h7FF;
  localparam logic [11:0] SAT_MIN = 12'h800;
  localparam logic signed [16:0] SAT_MAX17 = 17'sd2047;
  localparam logic signed [16:0] SAT_MIN17 = -17'sd2048;

  // Signed clamp of the 17-bit PID output into the CORDIC's 12-bit range.
  function automatic logic [11:0] sat12(input logic [16:0] v);
    if ($signed(v) > SAT_MAX17)      return SAT_MAX;
    else if ($signed(v) < SAT_MIN17) return SAT_MIN;
    else                             return v[11:0];
  endfunction

endpackage

// File: rtl/pid_cordic_tick_div.sv
// Sample-period divider: counts 0..DIV-1 while enabled, held at 0 otherwise.
// tick marks the last count of each period.
module pid_cordic_tick_div #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (!en)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pid_cordic_sched.sv
// Periodic sample/compute sequencer: latches ADC into PID, saturates the PID
// result into CORDIC and strobes out the magnitude; owns host config regs.
module pid_cordic_sched
  import pid_cordic_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int PID_LAT    = 4,
  parameter int CORDIC_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] adc_data,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [11:0] target,
  output logic [11:0] para,
  output logic [11:0] y,
  output logic        pid_we,
  output logic [11:0] pid_data,
  input  logic [16:0] pid_result,
  output logic        cordic_we,
  output logic [11:0] cordic_data,
  input  logic [11:0] cordic_result,
  output logic [11:0] mag_out,
  output logic        mag_valid,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int MAXL = (PID_LAT > CORDIC_LAT) ? PID_LAT : CORDIC_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tick;
  logic [11:0]   shadow_target, shadow_para;

  pid_cordic_tick_div #(.DIV(SAMPLE_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cordic_we = 1'b0;
    mag_valid = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_nxt = PID_WAIT;
        cnt_nxt   = CW'(PID_LAT);
      end
      PID_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = CORDIC_LOAD;
      end
      CORDIC_LOAD: begin
        cordic_we = 1'b1;
        cnt_nxt   = CW'(CORDIC_LAT);
        state_nxt = CORDIC_WAIT;
      end
      CORDIC_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        mag_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign pid_data = y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y             <= '0;
      target        <= '0;
      para          <= '0;
      pid_we        <= 1'b0;
      cordic_data   <= '0;
      mag_out       <= '0;
      cfg_ack       <= 1'b0;
      shadow_target <= '0;
      shadow_para   <= '0;
      overrun_cnt   <= '0;
    end else begin
      pid_we  <= (state == IDLE) && tick;
      cfg_ack <= cfg_wr;
      // Active setpoint/gains only move at an accepted sample boundary.
      if ((state == IDLE) && tick) begin
        y      <= adc_data;
        target <= shadow_target;
        para   <= shadow_para;
      end
      if ((state == PID_WAIT) && (cnt == CW'(1)))    cordic_data <= sat12(pid_result);
      if ((state == CORDIC_WAIT) && (cnt == CW'(1))) mag_out     <= cordic_result;
      if (cfg_wr && (cfg_addr == ADDR_TARGET)) shadow_target <= cfg_wdata;
      if (cfg_wr && (cfg_addr == ADDR_PARA))   shadow_para   <= cfg_wdata;
      // Host clear beats a coincident overrun.
      if (cfg_wr && (cfg_addr == ADDR_CTRL) && cfg_wdata[0])
        overrun_cnt <= '0;
      else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pid_cordic_sched.sv
// Scoreboard bench for pid_cordic_sched: a 40-cycle-period instance for the
// data path and a 10-cycle-period instance for overrun behaviour.
module tb_pid_cordic_sched;

  logic        clk = 1'b0;
  logic        rst, en, en_b, cfg_wr;
  logic [11:0] adc_data, cfg_wdata, cordic_result;
  logic [1:0]  cfg_addr;
  logic [16:0] pid_result;

  logic        cfg_ack, pid_we, cordic_we, mag_valid, busy;
  logic [11:0] target, para, y, pid_data, cordic_data, mag_out;
  logic [7:0]  overrun_cnt;

  logic        cfg_ack_b, pid_we_b, cordic_we_b, mag_valid_b, busy_b;
  logic [11:0] target_b, para_b, y_b, pid_data_b, cordic_data_b, mag_out_b;
  logic [7:0]  overrun_cnt_b;

  pid_cordic_sched #(.SAMPLE_DIV(40), .PID_LAT(4), .CORDIC_LAT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_data(adc_data),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
    .target(target), .para(para), .y(y), .pid_we(pid_we), .pid_data(pid_data),
    .pid_result(pid_result), .cordic_we(cordic_we), .cordic_data(cordic_data),
    .cordic_result(cordic_result), .mag_out(mag_out), .mag_valid(mag_valid),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  pid_cordic_sched #(.SAMPLE_DIV(10), .PID_LAT(4), .CORDIC_LAT(16)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .adc_data(adc_data),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack_b),
    .target(target_b), .para(para_b), .y(y_b), .pid_we(pid_we_b), .pid_data(pid_data_b),
    .pid_result(pid_result), .cordic_we(cordic_we_b), .cordic_data(cordic_data_b),
    .cordic_result(cordic_result), .mag_out(mag_out_b), .mag_valid(mag_valid_b),
    .busy(busy_b), .overrun_cnt(overrun_cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int c0 = 0;

  typedef struct {
    logic [11:0] cd;
    logic [11:0] mag;
  } exp_t;
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx();
    return cyc - c0;
  endfunction

  task automatic start_en();
    en = 1'b1;
    c0 = cyc;
  endtask

  task automatic step_to(input int n);
    while (idx() < n) step();
  endtask

  // sel: 0 = pid_we, 1 = cordic_we, 2 = mag_valid
  task automatic wait_sig(input int sel, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if ((sel == 0 && pid_we) || (sel == 1 && cordic_we) || (sel == 2 && mag_valid)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [11:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({busy, mag_valid, pid_we, cordic_we, cfg_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {busy, mag_valid, pid_we, cordic_we, cfg_ack});
    end
    checks++;
    if ({y, target, para, pid_data} !== 48'h0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {y, target, para, pid_data});
    end
    checks++;
    if ({cordic_data, mag_out, overrun_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_out got %h want 0", {cordic_data, mag_out, overrun_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    exp_t e;
    adc_data = 12'h123; pid_result = 17'h00800; cordic_result = 12'h321;
    sb.push_back('{cd: 12'h7FF, mag: 12'h321});
    start_en();
    wait_sig(0, 60, ok);
    checks++;
    if (!ok || idx() != 40) begin
      errors++; $display("FAIL pid_we_cycle got %0d (ok=%0d) want 40", idx(), ok);
    end
    checks++;
    if (y !== 12'h123 || pid_data !== 12'h123) begin
      errors++; $display("FAIL y_latch got y=%h pid_data=%h want 123", y, pid_data);
    end
    step();
    checks++;
    if (pid_we !== 1'b0) begin
      errors++; $display("FAIL pid_we_pulse got %b want 0", pid_we);
    end
    wait_sig(1, 30, ok);
    checks++;
    if (!ok || idx() != 44) begin
      errors++; $display("FAIL cordic_we_cycle got %0d (ok=%0d) want 44", idx(), ok);
    end
    wait_sig(2, 30, ok);
    checks++;
    if (!ok || idx() != 61) begin
      errors++; $display("FAIL mag_valid_cycle got %0d (ok=%0d) want 61", idx(), ok);
    end
    e = sb.pop_front();
    checks++;
    if (mag_out !== e.mag || cordic_data !== e.cd) begin
      errors++; $display("FAIL basic_result got mag=%h cd=%h want mag=%h cd=%h", mag_out, cordic_data, e.mag, e.cd);
    end
  endtask

  task automatic test_saturation();
    logic [16:0] pr [6] = '{17'h1F000, 17'h1FFFF, 17'h007FF, 17'h1F800, 17'h1F7FF, 17'h0007B};
    logic [11:0] cd [6] = '{12'h800, 12'hFFF, 12'h7FF, 12'h800, 12'h800, 12'h07B};
    bit ok;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      pid_result = pr[i];
      cordic_result = 12'h100 + 12'(i);
      sb.push_back('{cd: cd[i], mag: 12'h100 + 12'(i)});
      wait_sig(2, 80, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || cordic_data !== e.cd || mag_out !== e.mag) begin
        errors++; $display("FAIL sat_%0d got ok=%0d cd=%h mag=%h want cd=%h mag=%h", i, ok, cordic_data, mag_out, e.cd, e.mag);
      end
    end
  endtask

  task automatic test_cfg();
    bit ok;
    wait_sig(0, 80, ok);
    step();
    cfg_write(2'd0, 12'h0AA);
    checks++;
    if (cfg_ack !== 1'b1 || target !== 12'h000) begin
      errors++; $display("FAIL cfg_ack_target got ack=%b target=%h want ack=1 target=000", cfg_ack, target);
    end
    step();
    checks++;
    if (cfg_ack !== 1'b0) begin
      errors++; $display("FAIL cfg_ack_pulse got %b want 0", cfg_ack);
    end
    cfg_write(2'd1, 12'h5C3);
    cfg_write(2'd3, 12'hFFF);
    checks++;
    if (cfg_ack !== 1'b1) begin
      errors++; $display("FAIL cfg_ack_addr3 got %b want 1", cfg_ack);
    end
    wait_sig(0, 80, ok);
    checks++;
    if (!ok || target !== 12'h0AA || para !== 12'h5C3) begin
      errors++; $display("FAIL cfg_apply got target=%h para=%h want 0AA 5C3", target, para);
    end
    // write landing in the tick cycle itself must wait for the following tick
    for (int i = 0; i < 80 && (idx() % 40) != 39; i++) step();
    cfg_write(2'd0, 12'h055);
    checks++;
    if (pid_we !== 1'b1 || target !== 12'h0AA) begin
      errors++; $display("FAIL cfg_same_tick got pid_we=%b target=%h want 1 0AA", pid_we, target);
    end
    wait_sig(0, 80, ok);
    checks++;
    if (!ok || target !== 12'h055) begin
      errors++; $display("FAIL cfg_next_tick got target=%h want 055", target);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    wait_sig(1, 80, ok);
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mag_valid, pid_we, cordic_we, y, target, para, cordic_data, mag_out, overrun_cnt} !== 76'h0) begin
      errors++; $display("FAIL reset_mid got busy=%b y=%h target=%h cd=%h mag=%h want all 0", busy, y, target, cordic_data, mag_out);
    end
    sb.delete();
    en = 1'b0;
    step(); step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mag_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_no_mag got %0d active cycles want 0", seen);
    end
    adc_data = 12'h456;
    start_en();
    wait_sig(0, 60, ok);
    checks++;
    if (!ok || idx() != 40 || y !== 12'h456) begin
      errors++; $display("FAIL reset_restart got cycle=%0d y=%h want 40 456", idx(), y);
    end
  endtask

  task automatic test_en_off();
    bit ok;
    int seen;
    exp_t e;
    pid_result = 17'h00123; cordic_result = 12'h0EE;
    sb.push_back('{cd: 12'h123, mag: 12'h0EE});
    step();
    en = 1'b0;
    wait_sig(2, 40, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cordic_data !== e.cd || mag_out !== e.mag) begin
      errors++; $display("FAIL en_off_complete got ok=%0d cd=%h mag=%h want %h %h", ok, cordic_data, mag_out, e.cd, e.mag);
    end
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pid_we || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL en_off_hold got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_overrun();
    en_b = 1'b1;
    c0 = cyc;
    step_to(35);
    checks++;
    if (overrun_cnt_b !== 8'd2) begin
      errors++; $display("FAIL ovr_first got %0d want 2", overrun_cnt_b);
    end
    step_to(65);
    checks++;
    if (overrun_cnt_b !== 8'd4) begin
      errors++; $display("FAIL ovr_second got %0d want 4", overrun_cnt_b);
    end
    step_to(79);
    cfg_write(2'd2, 12'h001);
    checks++;
    if (overrun_cnt_b !== 8'd0) begin
      errors++; $display("FAIL ovr_clear_wins got %0d want 0", overrun_cnt_b);
    end
    step_to(90);
    checks++;
    if (overrun_cnt_b !== 8'd1) begin
      errors++; $display("FAIL ovr_after_clear got %0d want 1", overrun_cnt_b);
    end
    repeat (4000) step();
    checks++;
    if (overrun_cnt_b !== 8'hFF) begin
      errors++; $display("FAIL ovr_saturate got %0d want 255", overrun_cnt_b);
    end
    cfg_write(2'd2, 12'h000);
    step();
    checks++;
    if (overrun_cnt_b !== 8'hFF) begin
      errors++; $display("FAIL ovr_bit0_low got %0d want 255", overrun_cnt_b);
    end
    cfg_write(2'd2, 12'h001);
    checks++;
    if (overrun_cnt_b !== 8'd0) begin
      errors++; $display("FAIL ovr_clear_sat got %0d want 0", overrun_cnt_b);
    end
    en_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_b = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    adc_data = '0; pid_result = '0; cordic_result = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_cfg();
    test_reset_mid();
    test_en_off();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
